// File: rtl/sync_fifo_prog.sv
// Single-clock show-ahead FIFO with occupancy count, programmable almost flags and flush.
// Define SYNC_FIFO_ERR_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module sync_fifo_prog #(
  parameter int unsigned B      = 8,
  parameter int unsigned W      = 4,
  parameter int unsigned AF_LVL = 12,
  parameter int unsigned AE_LVL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int unsigned D     = 2 ** W;
  localparam logic [W:0]  DFull = (W + 1)'(D);
  localparam logic [W:0]  AfLvl = (W + 1)'(AF_LVL);
  localparam logic [W:0]  AeLvl = (W + 1)'(AE_LVL);

  logic [B-1:0] r_mem [D];
  logic [W-1:0] r_wptr;
  logic [W-1:0] r_rptr;
  logic [W:0]   r_count;
  logic         r_empty;
  logic         r_full;
  logic         r_aempty;
  logic         r_afull;

  logic         w_rd_ok;
  logic         w_wr_ok;
  logic [W:0]   w_count_nxt;

  // A full FIFO still takes a write when the same cycle pops the head.
  always_comb begin
    w_rd_ok     = rd & ~r_empty;
    w_wr_ok     = wr & (~r_full | rd);
    w_count_nxt = r_count;
    if (clr) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + (W + 1)'(w_wr_ok) - (W + 1)'(w_rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok && !clr) begin
      r_mem[r_wptr] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= (AF_LVL == 0);
    end else begin
      if (clr) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
        if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
      end
      r_count  <= w_count_nxt;
      r_empty  <= (w_count_nxt == '0);
      r_full   <= (w_count_nxt == DFull);
      r_aempty <= (w_count_nxt <= AeLvl);
      r_afull  <= (w_count_nxt >= AfLvl);
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic r_ovf;
  logic r_udf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (clr) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (wr && !w_wr_ok) r_ovf <= 1'b1;
      if (rd && r_empty)  r_udf <= 1'b1;
    end
  end

  assign overflow  = r_ovf;
  assign underflow = r_udf;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign r_data       = r_mem[r_rptr];
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_aempty;
  assign almost_full  = r_afull;
  assign count        = r_count;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: hand-derived vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_sync_fifo_prog;

`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] w_data = '0;
  logic       rd = 1'b0;
  logic [7:0] r_data;
  logic       empty, full, almost_empty, almost_full;
  logic [4:0] count;
  logic       overflow, underflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;

  typedef struct {
    logic       c;
    logic       w;
    logic       r;
    logic [7:0] d;
    int         ecount;
    logic       eempty;
    logic       efull;
    logic       chkd;
    logic [7:0] edata;
    logic       eudf;
    logic       eovf;
  } vec_t;

  vec_t tbl[8];

  sync_fifo_prog #(.B(8), .W(4), .AF_LVL(12), .AE_LVL(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= 4));
    chk({tag, ".afull"}, 32'(almost_full), 32'(n >= 12));
    chk({tag, ".ovf"}, 32'(overflow), 32'(ERR & m_ovf));
    chk({tag, ".udf"}, 32'(underflow), 32'(ERR & m_udf));
    if (n > 0) chk({tag, ".rdata"}, 32'(r_data), 32'(mq[0]));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".empty"}, 32'(empty), 32'd1);
    chk({tag, ".full"}, 32'(full), 32'd0);
    chk({tag, ".aempty"}, 32'(almost_empty), 32'd1);
    chk({tag, ".afull"}, 32'(almost_full), 32'd0);
    chk({tag, ".ovf"}, 32'(overflow), 32'd0);
    chk({tag, ".udf"}, 32'(underflow), 32'd0);
  endtask

  task automatic model_update(input logic c, input logic w, input logic [7:0] d, input logic r);
    bit rd_ok;
    bit wr_ok;
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      rd_ok = r && (mq.size() != 0);
      wr_ok = w && ((mq.size() < DEPTH) || r);
      if (r && mq.size() == 0) m_udf = 1'b1;
      if (w && !wr_ok) m_ovf = 1'b1;
      if (rd_ok) void'(mq.pop_front());
      if (wr_ok) mq.push_back(d);
    end
  endtask

  task automatic step(input logic c, input logic w, input logic [7:0] d, input logic r);
    clr    = c;
    wr     = w;
    w_data = d;
    rd     = r;
    @(posedge clk);
    #1;
    model_update(c, w, d, r);
    clr = 1'b0;
    wr  = 1'b0;
    rd  = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b1, 8'h55, 1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h77, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h33, 1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h44, 2, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;

    // Fill to full, then one write too many.
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0);
      check_model($sformatf("fill%0d", i));
    end
    chk("fill.full", 32'(full), 32'd1);
    step(1'b0, 1'b1, 8'hEE, 1'b0);
    check_model("wr17");
    chk("wr17.ovf", 32'(overflow), 32'(ERR));

    // Simultaneous pop/push while full.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'hAA, 1'b1);
      check_model($sformatf("rdwr%0d", i));
    end
    chk("rdwr.count", 32'(count), 32'd16);
    chk("rdwr.head", 32'(r_data), 32'h05);

    // Drain, then read from empty.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check_model($sformatf("drain%0d", i));
    end
    chk("drain.empty", 32'(empty), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check_model("rd_empty");
    chk("rd_empty.udf", 32'(underflow), 32'(ERR));
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check_model("clr0");

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].c, tbl[i].w, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].ecount));
      chk($sformatf("tbl%0d.empty", i), 32'(empty), 32'(tbl[i].eempty));
      chk($sformatf("tbl%0d.full", i), 32'(full), 32'(tbl[i].efull));
      chk($sformatf("tbl%0d.udf", i), 32'(underflow), 32'(ERR & tbl[i].eudf));
      chk($sformatf("tbl%0d.ovf", i), 32'(overflow), 32'(ERR & tbl[i].eovf));
      if (tbl[i].chkd) chk($sformatf("tbl%0d.rdata", i), 32'(r_data), 32'(tbl[i].edata));
      check_model($sformatf("tblm%0d", i));
    end

    // Flush with a concurrent write: the write must be dropped.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    check_model("load8");
    step(1'b1, 1'b1, 8'h99, 1'b0);
    check_model("flush");
    chk("flush.count", 32'(count), 32'd0);
    step(1'b0, 1'b1, 8'h33, 1'b0);
    check_model("after_flush");
    chk("after_flush.rdata", 32'(r_data), 32'h33);

    // Randomized traffic with an async reset dropped in mid-stream.
    for (int i = 0; i < 600; i++) begin
      int pw;
      pw = ((i / 50) % 2 == 0) ? 70 : 30;
      if (i == 300) begin
        step(1'b0, 1'b1, 8'h5A, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      step(1'b0, 1'b0, 8'h00, 1'b0);
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < pw),
           8'($urandom), ($urandom_range(0, 99) < (100 - pw)));
      check_model($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
